// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave
//   AHB-Lite on-chip SRAM target. It decodes against BASE_ADDR and takes a byte address.
//   Writes use byte lanes selected by HSIZE and the low address bits (little-endian).
//   Every OKAY data phase gets WAIT_STATES wait cycles.
//   Bad transfers get the two-cycle ERROR response. A bad transfer is one that is out of
//   range, oversized or misaligned.
//   A read that completes behind a write to the same word returns the merged post-write word.
//
// Ports
//   HCLK       in   clock
//   HRESETn    in   asynchronous active-low reset
//   HSEL       in   slave select from the decoder
//   HADDR      in   byte address (address phase)
//   HTRANS     in   IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
//   HWRITE     in   1 = write
//   HSIZE      in   transfer size, 2^HSIZE bytes
//   HWDATA     in   write data (data phase)
//   HREADY     in   bus ready from the mux
//   HRDATA     out  registered read data, full word
//   HREADYOUT  out  slave ready
//   HRESP      out  0 = OKAY, 1 = ERROR
module ahb_lite_sram_slave #(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
    parameter int unsigned            WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int unsigned      Bytes    = DATA_WIDTH / 8;
    localparam int unsigned      OffBits  = $clog2(Bytes);
    localparam int unsigned      IdxW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned      CntW     = 4;
    localparam longint unsigned  MemBytes = longint'(MEM_DEPTH) * longint'(Bytes);

    // Elaboration-time parameter checks
    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
        $error("ahb_lite_sram_slave: DATA_WIDTH must be 32 or 64");
    end
    if (WAIT_STATES > 15) begin : g_bad_wait_states
        $error("ahb_lite_sram_slave: WAIT_STATES must be 0..15");
    end

    typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   dp_valid_q, dp_valid_d;
    logic                   dp_write_q, dp_write_d;
    logic [IdxW-1:0]        dp_idx_q, dp_idx_d;
    logic [Bytes-1:0]       dp_be_q, dp_be_d;
    logic [DATA_WIDTH-1:0]  hrdata_q, hrdata_d;

    logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];

    logic                   hreadyout;
    logic                   hresp;

    // HTRANS[0] only separates IDLE/BUSY and NONSEQ/SEQ; both pairs behave alike here
    logic unused_htrans;
    assign unused_htrans = HTRANS[0];

    // ------------------------------------------------------------------------
    // Address-phase decode and checks
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]  offset;
    logic                   below_base;
    logic                   out_of_range;
    logic                   size_err;
    logic                   misalign;
    logic [2:0]             align_mask;
    logic [7:0]             size_be;
    logic [Bytes-1:0]       addr_be;
    logic [IdxW-1:0]        addr_idx;
    logic                   accept;
    logic                   acc_ok;
    logic                   acc_err;

    assign offset       = HADDR - BASE_ADDR;
    assign below_base   = HADDR < BASE_ADDR;
    assign out_of_range = below_base || (64'(offset) >= MemBytes);
    assign size_err     = HSIZE > 3'(OffBits);
    assign addr_idx     = offset[OffBits +: IdxW];

    always_comb begin
        align_mask = 3'b111;
        size_be    = 8'hff;
        unique case (HSIZE)
            3'd0: begin align_mask = 3'b000; size_be = 8'h01; end
            3'd1: begin align_mask = 3'b001; size_be = 8'h03; end
            3'd2: begin align_mask = 3'b011; size_be = 8'h0f; end
            default: begin align_mask = 3'b111; size_be = 8'hff; end
        endcase
    end

    assign misalign = |(HADDR[2:0] & align_mask);
    assign addr_be  = Bytes'(size_be) << offset[OffBits-1:0];

    // Acceptance is also gated by our own ready so a misbehaving mux cannot
    // slip a new transfer in under a stalled data phase.
    assign accept  = HSEL && HREADY && HTRANS[1] && hreadyout;
    assign acc_err = accept && (out_of_range || size_err || misalign);
    assign acc_ok  = accept && !(out_of_range || size_err || misalign);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StErr2: begin
                state_d = StIdle;
                if (acc_err) begin
                    state_d = StErr1;
                end else if (acc_ok && (WAIT_STATES > 0)) begin
                    state_d = StWait;
                    cnt_d   = CntW'(WAIT_STATES - 1);
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        unique case (state_q)
            StWait: hreadyout = 1'b0;
            StErr1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            StErr2:  hresp = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Data-phase tracking of the accepted good transfer
    // ------------------------------------------------------------------------
    always_comb begin
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_idx_d   = dp_idx_q;
        dp_be_d    = dp_be_q;
        // Whenever we are ready, the current data phase (if any) ends on this edge
        if (hreadyout) begin
            dp_valid_d = 1'b0;
        end
        if (acc_ok) begin
            dp_valid_d = 1'b1;
            dp_write_d = HWRITE;
            dp_idx_d   = addr_idx;
            dp_be_d    = addr_be;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_idx_q   <= '0;
            dp_be_q    <= '0;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_idx_q   <= dp_idx_d;
            dp_be_q    <= dp_be_d;
        end
    end

    // ------------------------------------------------------------------------
    // Write commit and read path
    // ------------------------------------------------------------------------
    logic                   commit;
    logic                   rd_fire;
    logic [IdxW-1:0]        rd_idx;
    logic [DATA_WIDTH-1:0]  rd_word;

    // Good data phases only exist in IDLE/WAIT, so ready implies a non-ERR state
    assign commit = dp_valid_q && dp_write_q && hreadyout;

    always_comb begin
        if (WAIT_STATES == 0) begin
            // Zero-wait: the array is read on the acceptance edge
            rd_fire = acc_ok && !HWRITE;
            rd_idx  = addr_idx;
        end else begin
            // Read on the edge leaving the last wait cycle
            rd_fire = (state_q == StWait) && (cnt_q == '0) && dp_valid_q && !dp_write_q;
            rd_idx  = dp_idx_q;
        end
    end

    // Forward lanes of a write committing on the same edge to the same word
    always_comb begin
        rd_word = mem_q[rd_idx];
        for (int b = 0; b < int'(Bytes); b++) begin
            if (commit && (dp_idx_q == rd_idx) && dp_be_q[b]) begin
                rd_word[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
        hrdata_d = rd_fire ? rd_word : hrdata_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hrdata_q <= '0;
        end else begin
            hrdata_q <= hrdata_d;
        end
    end

    // Array has no reset; commit is held low while HRESETn is asserted
    always_ff @(posedge HCLK) begin
        for (int b = 0; b < int'(Bytes); b++) begin
            if (commit && dp_be_q[b]) begin
                mem_q[dp_idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hreadyout;
    assign HRESP     = hresp;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb_ahb_lite_sram_slave
//   Three slaves on one shared AHB-Lite bus:
//     u_dut0: 32-bit data, zero wait states, base 0
//     u_dut1: 32-bit data, three wait states, base 0
//     u_dut2: 64-bit data, one wait state, base 0x4000_0000
//   A pipelined master drives queued transfers. A transfer-level reference model predicts the
//   response timing, read data and HRDATA hold behaviour.
module tb_ahb_lite_sram_slave;

    localparam int unsigned Depth = 1024;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [2:0]  hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [63:0] hwdata;
    logic        hready;
    logic [31:0] rdata0, rdata1;
    logic [63:0] rdata2;
    logic [2:0]  ro, rp;

    always #5 HCLK = ~HCLK;

    // Unselected slaves always sit ready, so the mux output is the AND of all
    assign hready = &ro;

    ahb_lite_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(Depth),
        .BASE_ADDR(32'h0), .WAIT_STATES(0)
    ) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata[31:0]), .HREADY(hready),
        .HRDATA(rdata0), .HREADYOUT(ro[0]), .HRESP(rp[0])
    );

    ahb_lite_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(Depth),
        .BASE_ADDR(32'h0), .WAIT_STATES(3)
    ) u_dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata[31:0]), .HREADY(hready),
        .HRDATA(rdata1), .HREADYOUT(ro[1]), .HRESP(rp[1])
    );

    ahb_lite_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_DEPTH(Depth),
        .BASE_ADDR(32'h4000_0000), .WAIT_STATES(1)
    ) u_dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(rdata2), .HREADYOUT(ro[2]), .HRESP(rp[2])
    );

    typedef struct {
        int          dut;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
    } xfer_t;

    xfer_t       seq_q[$];
    logic [63:0] mdl_mem [int];
    logic [63:0] mdl_rd [3];
    logic [63:0] obs_rd [3];
    int          obs_rd_wait [3];
    int          n_checks = 0;
    int          n_pass = 0;

    // ------------------------------------------------------------------------
    // Per-slave configuration and reference model
    // ------------------------------------------------------------------------
    function automatic int unsigned dw_of(int d);
        return (d == 2) ? 64 : 32;
    endfunction

    function automatic int unsigned ws_of(int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 1);
    endfunction

    function automatic longint unsigned base_of(int d);
        return (d == 2) ? 64'h4000_0000 : 64'h0;
    endfunction

    function automatic int key_of(int d, longint unsigned idx);
        return d * 4096 + int'(idx);
    endfunction

    function automatic bit exp_err(xfer_t x);
        longint unsigned nb = longint'(dw_of(x.dut) / 8);
        longint unsigned a  = longint'(x.addr);
        longint unsigned b  = base_of(x.dut);
        longint unsigned sz = longint'(1) << x.size;
        if (a < b) return 1'b1;
        if (a - b >= longint'(Depth) * nb) return 1'b1;
        if (sz > nb) return 1'b1;
        if (a % sz != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int word_key(xfer_t x);
        longint unsigned nb = longint'(dw_of(x.dut) / 8);
        return key_of(x.dut, (longint'(x.addr) - base_of(x.dut)) / nb);
    endfunction

    function automatic void mdl_write(xfer_t x);
        longint unsigned nb   = longint'(dw_of(x.dut) / 8);
        int              lane = int'((longint'(x.addr) - base_of(x.dut)) % nb);
        int              k    = word_key(x);
        logic [63:0]     w    = mdl_mem.exists(k) ? mdl_mem[k] : 64'h0;
        for (int i = 0; i < (1 << x.size); i++) begin
            w[8*(lane+i) +: 8] = x.wdata[8*(lane+i) +: 8];
        end
        mdl_mem[k] = w;
    endfunction

    function automatic logic [63:0] rdata_of(int d);
        if (d == 0) return {32'h0, rdata0};
        if (d == 1) return {32'h0, rdata1};
        return rdata2;
    endfunction

    function automatic void push(int d, logic [1:0] t, logic wr, logic [31:0] a,
                                 logic [2:0] s, logic [63:0] w);
        xfer_t x;
        x.dut = d; x.trans = t; x.wr = wr; x.addr = a; x.size = s; x.wdata = w;
        seq_q.push_back(x);
    endfunction

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Pipelined master: call just after a negedge
    // ------------------------------------------------------------------------
    task automatic drive_addr(bit act, xfer_t x);
        hsel   = 3'b000;
        htrans = 2'b00;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = 3'd0;
        if (act) begin
            hsel[x.dut] = 1'b1;
            htrans      = x.trans;
            haddr       = x.addr;
            hwrite      = x.wr;
            hsize       = x.size;
        end
    endtask

    task automatic run_seq();
        xfer_t       ap, dp;
        bit          ap_act = 1'b0, dp_act = 1'b0, dp_err = 1'b0;
        int          dp_cyc = 0, stall = 0, n_ok, d;
        logic [1:0]  exp_rsp;
        logic [63:0] exp_rd;
        while (seq_q.size() > 0 || ap_act || dp_act) begin
            if (!ap_act && seq_q.size() > 0) begin
                ap     = seq_q.pop_front();
                ap_act = 1'b1;
            end
            drive_addr(ap_act, ap);
            if (dp_act) begin
                d    = dp.dut;
                n_ok = dp.trans[1] ? int'(ws_of(d)) : 0;
                if (dp_err) exp_rsp = (dp_cyc == 0) ? 2'b01 : 2'b11;
                else        exp_rsp = (dp_cyc < n_ok) ? 2'b00 : 2'b10;
                check_eq($sformatf("d%0d rsp a=%h cyc%0d", d, dp.addr, dp_cyc),
                         {62'h0, hready, rp[d]}, {62'h0, exp_rsp});
                if (hready) begin
                    if (dp.trans[1]) begin
                        if (dp_err) begin
                            check_eq($sformatf("d%0d err hold", d), rdata_of(d), mdl_rd[d]);
                        end else if (!dp.wr) begin
                            exp_rd = mdl_mem[word_key(dp)];
                            check_eq($sformatf("d%0d rdata a=%h", d, dp.addr), rdata_of(d), exp_rd);
                            mdl_rd[d]      = exp_rd;
                            obs_rd[d]      = rdata_of(d);
                            obs_rd_wait[d] = dp_cyc;
                        end else begin
                            mdl_write(dp);
                        end
                    end
                    dp_act = 1'b0;
                end
            end
            if (hready) begin
                stall = 0;
                if (ap_act) begin
                    dp     = ap;
                    dp_act = 1'b1;
                    dp_cyc = 0;
                    dp_err = ap.trans[1] && exp_err(ap);
                    ap_act = 1'b0;
                end
            end else begin
                stall++;
                if (dp_act) dp_cyc++;
                if (stall > 40) begin
                    check_eq("bus stall timeout", {63'h0, hready}, 64'h1);
                    dp_act = 1'b0;
                    ap_act = 1'b0;
                    seq_q.delete();
                end
            end
            @(posedge HCLK);
            #1;
            hwdata = (dp_act && dp.wr) ? dp.wdata : 64'h0;
            @(negedge HCLK);
        end
        drive_addr(1'b0, ap);
    endtask

    // Preload a small window, then random mixed traffic incl. bad transfers
    task automatic gen_random(int d, int n);
        int unsigned     nb = dw_of(d) / 8;
        int unsigned     maxsz = (nb == 8) ? 3 : 2;
        int unsigned     r, sz;
        longint unsigned off;
        logic [31:0]     a;
        logic [1:0]      t;
        for (int i = 0; i < 16; i++) begin
            push(d, 2'b10, 1'b1, 32'(base_of(d) + longint'(i * nb)), 3'(maxsz),
                 {$urandom, $urandom});
        end
        for (int i = 0; i < n; i++) begin
            r   = $urandom_range(0, 99);
            sz  = (r < 10) ? maxsz + 1 : $urandom_range(0, maxsz);
            off = longint'($urandom_range(0, 16 * nb - 1));
            if (r >= 15) off = off & ~((longint'(1) << sz) - 1);
            if (r >= 10 && r < 13) off = longint'(Depth * nb + $urandom_range(0, 64));
            a = 32'(base_of(d) + off);
            if (d == 2 && r == 13) a = 32'(base_of(d) - 8 * $urandom_range(1, 4));
            t = (r < 3) ? 2'b00 : ((r < 6) ? 2'b01 : (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10));
            push(d, t, 1'($urandom_range(0, 1)), a, 3'(sz), {$urandom, $urandom});
        end
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        logic [63:0] prev;
        hsel = 3'b000; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
        hwdata = 64'h0;
        for (int i = 0; i < 3; i++) begin
            mdl_rd[i] = 64'h0; obs_rd[i] = 64'h0; obs_rd_wait[i] = -1;
        end
        repeat (3) @(posedge HCLK);
        #1;
        check_eq("reset hreadyout", {61'h0, ro}, 64'h7);
        check_eq("reset hresp", {61'h0, rp}, 64'h0);
        for (int i = 0; i < 3; i++) check_eq($sformatf("reset hrdata d%0d", i), rdata_of(i), 64'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Back-to-back write then read, zero wait: forwarding
        push(0, 2'b10, 1'b1, 32'h10, 3'd2, 64'hCAFE_F00D);
        push(0, 2'b10, 1'b0, 32'h10, 3'd2, 64'h0);
        run_seq();
        check_eq("fwd read", obs_rd[0], 64'hCAFE_F00D);

        // Byte and halfword lanes
        push(0, 2'b10, 1'b1, 32'h20, 3'd2, 64'h1122_3344);
        push(0, 2'b10, 1'b1, 32'h22, 3'd0, 64'h00AA_0000);
        push(0, 2'b10, 1'b1, 32'h20, 3'd1, 64'h0000_BEEF);
        push(0, 2'b10, 1'b0, 32'h20, 3'd2, 64'h0);
        run_seq();
        check_eq("lane merge", obs_rd[0], 64'h11AA_BEEF);

        // Out-of-range read, then an idle cycle; misaligned and oversized writes
        push(0, 2'b10, 1'b0, 32'h1000, 3'd2, 64'h0);
        push(0, 2'b00, 1'b0, 32'h0, 3'd0, 64'h0);
        push(0, 2'b10, 1'b1, 32'h21, 3'd1, 64'hFFFF_FFFF);
        push(0, 2'b10, 1'b1, 32'h20, 3'd3, 64'hFFFF_FFFF);
        push(0, 2'b10, 1'b0, 32'h20, 3'd2, 64'h0);
        run_seq();
        check_eq("err no write", obs_rd[0], 64'h11AA_BEEF);

        // Wait states, plus IDLE and BUSY while selected
        push(1, 2'b10, 1'b1, 32'h4, 3'd2, 64'h5A5A_5A5A);
        push(1, 2'b10, 1'b0, 32'h4, 3'd2, 64'h0);
        push(1, 2'b00, 1'b0, 32'h8, 3'd2, 64'h0);
        push(1, 2'b01, 1'b0, 32'h8, 3'd2, 64'h0);
        run_seq();
        check_eq("ws read data", obs_rd[1], 64'h5A5A_5A5A);
        check_eq("ws read waits", 64'(obs_rd_wait[1]), 64'd3);

        // 64-bit slave at a non-zero base
        push(2, 2'b10, 1'b1, 32'h4000_0008, 3'd3, 64'h0123_4567_89AB_CDEF);
        push(2, 2'b10, 1'b0, 32'h4000_0008, 3'd3, 64'h0);
        push(2, 2'b10, 1'b0, 32'h3FFF_FFF8, 3'd3, 64'h0);
        run_seq();
        check_eq("dw read", obs_rd[2], 64'h0123_4567_89AB_CDEF);

        for (int d = 0; d < 3; d++) begin
            gen_random(d, 150);
            run_seq();
        end

        // Reset during a wait cycle drops the pending write
        prev = mdl_mem[key_of(2, 1)];
        drive_addr(1'b1, '{dut: 2, trans: 2'b10, wr: 1'b1, addr: 32'h4000_0008, size: 3'd3,
                           wdata: 64'h0});
        @(posedge HCLK);
        #1;
        drive_addr(1'b0, '{dut: 0, trans: 2'b00, wr: 1'b0, addr: 32'h0, size: 3'd0,
                           wdata: 64'h0});
        hwdata = 64'hDEAD_BEEF_0000_1111;
        check_eq("pre-reset wait", {63'h0, ro[2]}, 64'h0);
        #2;
        HRESETn = 1'b0;
        #1;
        check_eq("async rst hreadyout", {63'h0, ro[2]}, 64'h1);
        check_eq("async rst hresp", {63'h0, rp[2]}, 64'h0);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        hwdata = 64'h0;
        for (int i = 0; i < 3; i++) mdl_rd[i] = 64'h0;
        @(negedge HCLK);
        push(2, 2'b10, 1'b0, 32'h4000_0008, 3'd3, 64'h0);
        run_seq();
        check_eq("write dropped", obs_rd[2], prev);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
Parametrised AHB-Lite SRAM slave. It is the successor to the fixed 1K-word slave. It adds:
- HSEL decode against a base address
- byte-addressed HADDR with byte-lane writes
- alignment and size checks
- a programmable number of wait states
- the spec-compliant two-cycle ERROR response
- write-to-read forwarding

It sits behind the AHB-Lite decoder/mux as a generic on-chip memory target.

Parameters:
- ADDR_WIDTH, 32, width of HADDR.
- DATA_WIDTH, 32, data bus width. Legal values are 32 and 64.
- MEM_DEPTH, 1024, number of DATA_WIDTH-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase. Range is 0..15.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select from decoder
- HADDR  in  ADDR_WIDTH  byte address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1=write
- HSIZE  in  3  transfer size, 2^HSIZE bytes
- HWDATA  in  DATA_WIDTH  write data, valid in data phase
- HREADY  in  1  bus ready (mux output)
- HRDATA  out  DATA_WIDTH  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR

Behaviour:
Interface:
- One clock, HCLK. Reset HRESETn is asynchronous and active-low.
- Reset values: HRDATA=0, HREADYOUT=1, HRESP=0, FSM=IDLE, wait counter=0, no pending write. Memory contents are not reset.
- Reset asserted mid-transfer aborts the transfer. An uncommitted write is dropped.

Address phase:
- A transfer is accepted on a rising edge with HSEL & HREADY & HTRANS[1].
- On acceptance, register HADDR, HWRITE and HSIZE.
- Compute offset = HADDR - BASE_ADDR and word index = offset >> log2(DATA_WIDTH/8).
- IDLE or BUSY with HSEL, or HSEL low: nothing is captured. The next cycle is zero-wait OKAY.

Error check (made at acceptance):
- Offset outside 0..MEM_DEPTH*DATA_WIDTH/8-1, or HADDR < BASE_ADDR.
- 2^HSIZE > DATA_WIDTH/8.
- HADDR not aligned to 2^HSIZE.
- Any error goes to ERR1. Memory is untouched and HRDATA is unchanged.

FSM states are IDLE, WAIT, ERR1 and ERR2.
- IDLE: HREADYOUT=1, HRESP=0.
  - An accepted good transfer goes to WAIT if WAIT_STATES>0. Otherwise it stays in IDLE and completes in the next cycle.
  - An accepted bad transfer goes to ERR1.
- WAIT: HREADYOUT=0, HRESP=0.
  - Counter loads WAIT_STATES-1 and decrements each cycle.
  - At 0, go to IDLE. The following cycle is the completing cycle with HREADYOUT=1.
- ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
- ERR2: HREADYOUT=1, HRESP=1. Goes to IDLE.
  - A transfer presented in this cycle is accepted normally, because HREADY=1.
- Data phase length is WAIT_STATES+1 cycles for OKAY and exactly 2 cycles for ERROR.

Writes:
- Commit on the edge ending the data phase, when HREADYOUT=1 and the state is not ERR.
- Only the byte lanes selected by HSIZE and the low address bits are written, little-endian. Byte at offset k uses HWDATA[8k+7:8k].
- HWDATA is sampled only on the committing edge.

Reads:
- HRDATA is registered and presents the full word, not lane-masked.
- It is valid throughout the completing cycle and held until the next read completes.
- For WAIT_STATES=0 the memory is read at the acceptance edge.
- Forwarding: a read accepted on the same edge a write commits to the same word returns the merged post-write word. Back-to-back write then read never returns stale data.

Wrap:
- The word index never wraps. Out-of-range addresses always produce ERROR.

Elaboration:
- An illegal DATA_WIDTH or WAIT_STATES stops elaboration with $error.

Test Plan:
1. DATA_WIDTH=32, WAIT_STATES=0. Write word 32'hCAFE_F00D @0x10, then read @0x10 back-to-back. Required: zero-wait OKAY on both; read returns 32'hCAFEF00D via forwarding.
2. Byte and halfword lanes.
   - Write word 0x11223344 @0x20.
   - Write byte 0xAA @0x22 (HSIZE=0, HWDATA=0x00AA0000).
   - Write halfword 0xBEEF @0x20 (HSIZE=1).
   - Read @0x20. Required: 0x11AABEEF.
3. Out-of-range read @MEM_DEPTH*4 = 0x1000.
   - Required: HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, then IDLE.
   - HRDATA is unchanged and memory is unaffected.
4. Misaligned halfword write @0x21 gives the 2-cycle ERROR. Word @0x20 is unchanged. HSIZE=3 on a 32-bit bus also gives ERROR.
5. WAIT_STATES=3. Read @0x4 after writing 0x5A5A5A5A.
   - Required: HREADYOUT low for exactly 3 cycles, then high with HRDATA=0x5A5A5A5A, HRESP=0.
   - IDLE and BUSY transfers with HSEL=1 still get a zero-wait OKAY.
6. BASE_ADDR=0x4000_0000, DATA_WIDTH=64.
   - Write doubleword @0x4000_0008, read it back. Required: same value.
   - Access @0x3FFF_FFF8 gives ERROR.
   - Assert HRESETn low during a WAIT cycle. Required: HREADYOUT=1 and HRESP=0 immediately; the pending write is not committed.
